// File: rtl/bus_arb_pkg.sv
// Shared arbitration types for the system bus: arbiter state encoding and master IDs,
// also used by the bus mux to decode bus_sel.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrantM1 = 2'd1,
        StGrantM2 = 2'd2
    } arb_state_e;

    localparam logic MASTER1 = 1'b0;
    localparam logic MASTER2 = 1'b1;

    function automatic arb_state_e grant_state(input logic master);
        return (master == MASTER2) ? StGrantM2 : StGrantM1;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the two bus masters and the arbiter.
interface bus_arbiter_if;

    logic m1_req;
    logic m1_lock;
    logic m2_req;
    logic m2_lock;
    logic txn_done;
    logic m1_grant;
    logic m2_grant;
    logic bus_sel;
    logic bus_busy;
    logic timeout_pulse;

    modport master (
        output m1_req, m1_lock, m2_req, m2_lock, txn_done,
        input  m1_grant, m2_grant, bus_sel, bus_busy, timeout_pulse
    );

    modport slave (
        input  m1_req, m1_lock, m2_req, m2_lock, txn_done,
        output m1_grant, m2_grant, bus_sel, bus_busy, timeout_pulse
    );

endinterface

// File: rtl/arb_hold_timer.sv
// Saturating hold counter for a bus grant; expired_o flags the cycle whose increment
// would bring the count to MAX_HOLD.
module arb_hold_timer #(
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MAX_HOLD);
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_HOLD - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign expired_o = en_i && !clr_i && (cnt_q == CntLast);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master system bus arbiter: fixed or round-robin tie-break, bounded locked bursts,
// and revocation of grants that stall past the hold timeout.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned PRIORITY_MODE = 1,
    parameter int unsigned MAX_HOLD      = 64,
    parameter int unsigned LOCK_MAX      = 4
) (
    input logic          clk,
    input logic          reset,
    bus_arbiter_if.slave bus
);

    localparam int unsigned LockW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [LockW-1:0] LockLast = LockW'(LOCK_MAX - 1);

    arb_state_e      state_q, state_d;
    logic [LockW-1:0] lock_q, lock_d;
    logic [1:0]      ban_q, ban_d;
    logic            last_q, last_d;
    logic            sel_q, sel_d;
    logic            timeout_q, timeout_d;
    logic            m1_grant_q, m2_grant_q, busy_q;

    logic [1:0] req, lock, elig;
    logic       pick, owner, rel, hold_expired, timer_clr, timer_en;

    assign req   = {bus.m2_req, bus.m1_req};
    assign lock  = {bus.m2_lock, bus.m1_lock};
    assign elig  = req & ~ban_q;
    assign owner = (state_q == StGrantM2) ? MASTER2 : MASTER1;

    // Counter restarts on every entry into a grant and on each completed transaction.
    assign timer_clr = (state_q == StIdle) || bus.txn_done;
    assign timer_en  = (state_q != StIdle);

    arb_hold_timer #(
        .MAX_HOLD(MAX_HOLD)
    ) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (timer_clr),
        .en_i     (timer_en),
        .expired_o(hold_expired)
    );

    always_comb begin
        pick = MASTER1;
        if (elig[0] && elig[1]) begin
            pick = (PRIORITY_MODE != 0) ? ~last_q : MASTER1;
        end else if (elig[1]) begin
            pick = MASTER2;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        last_d    = last_q;
        sel_d     = sel_q;
        timeout_d = 1'b0;
        ban_d     = ban_q & req;
        rel       = 1'b0;

        unique case (state_q)
            StIdle: begin
                lock_d = '0;
                if (|elig) begin
                    state_d = grant_state(pick);
                    sel_d   = pick;
                end
            end
            StGrantM1, StGrantM2: begin
                // Dropping req outranks everything, then txn_done, then the hold timeout.
                if (!req[owner]) begin
                    rel = 1'b1;
                end else if (bus.txn_done) begin
                    if (!lock[owner] || ((lock_q == LockLast) && req[~owner])) begin
                        rel = 1'b1;
                    end else if (lock_q != LockLast) begin
                        lock_d = lock_q + LockW'(1);
                    end
                end else if (hold_expired) begin
                    rel          = 1'b1;
                    timeout_d    = 1'b1;
                    ban_d[owner] = 1'b1;
                end
                if (rel) begin
                    state_d = StIdle;
                    last_d  = owner;
                    lock_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            lock_q     <= '0;
            ban_q      <= '0;
            last_q     <= MASTER2;
            sel_q      <= MASTER1;
            timeout_q  <= 1'b0;
            m1_grant_q <= 1'b0;
            m2_grant_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            ban_q      <= ban_d;
            last_q     <= last_d;
            sel_q      <= sel_d;
            timeout_q  <= timeout_d;
            m1_grant_q <= (state_d == StGrantM1);
            m2_grant_q <= (state_d == StGrantM2);
            busy_q     <= (state_d != StIdle);
        end
    end

    assign bus.m1_grant      = m1_grant_q;
    assign bus.m2_grant      = m2_grant_q;
    assign bus.bus_sel       = sel_q;
    assign bus.bus_busy      = busy_q;
    assign bus.timeout_pulse = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a round-robin and a fixed-priority instance share stimulus and are
// compared each cycle with a behavioural model, plus directed vector tables and sequences.
module tb_bus_arbiter;

    localparam int MaxHold = 64;
    localparam int LockMax = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic r1 = 1'b0, l1 = 1'b0, r2 = 1'b0, l2 = 1'b0, done = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    bus_arbiter_if if_rr ();
    bus_arbiter_if if_fx ();

    assign if_rr.m1_req   = r1;
    assign if_rr.m1_lock  = l1;
    assign if_rr.m2_req   = r2;
    assign if_rr.m2_lock  = l2;
    assign if_rr.txn_done = done;
    assign if_fx.m1_req   = r1;
    assign if_fx.m1_lock  = l1;
    assign if_fx.m2_req   = r2;
    assign if_fx.m2_lock  = l2;
    assign if_fx.txn_done = done;

    bus_arbiter #(
        .PRIORITY_MODE(1),
        .MAX_HOLD     (MaxHold),
        .LOCK_MAX     (LockMax)
    ) u_rr (
        .clk  (clk),
        .reset(reset),
        .bus  (if_rr)
    );

    bus_arbiter #(
        .PRIORITY_MODE(0),
        .MAX_HOLD     (MaxHold),
        .LOCK_MAX     (LockMax)
    ) u_fx (
        .clk  (clk),
        .reset(reset),
        .bus  (if_fx)
    );

    // Reference model, index 0 = round-robin instance, 1 = fixed-priority instance.
    // Masters are numbered 1 and 2; owner 0 means the bus is free.
    int m_owner[2];
    int m_quiet[2];
    int m_chain[2];
    int m_last[2];
    bit m_ban[2][3];
    bit m_sel[2];
    bit m_tmo[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = 0;
            m_quiet[k] = 0;
            m_chain[k] = 0;
            m_last[k]  = 2;
            m_sel[k]   = 1'b0;
            m_tmo[k]   = 1'b0;
            for (int i = 0; i < 3; i++) m_ban[k][i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit rq[3];
        bit lk[3];
        bit leave;
        int o;
        int w;
        rq[1] = r1; rq[2] = r2; lk[1] = l1; lk[2] = l2;
        rq[0] = 1'b0; lk[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            o = m_owner[k];
            m_tmo[k] = 1'b0;
            if (o == 0) begin
                w = 0;
                if (rq[1] && !m_ban[k][1] && rq[2] && !m_ban[k][2])
                    w = (k == 0) ? ((m_last[k] == 1) ? 2 : 1) : 1;
                else if (rq[1] && !m_ban[k][1]) w = 1;
                else if (rq[2] && !m_ban[k][2]) w = 2;
                if (w != 0) begin
                    m_owner[k] = w;
                    m_sel[k]   = (w == 2);
                    m_quiet[k] = 0;
                    m_chain[k] = 0;
                end
            end else begin
                leave = 1'b0;
                m_quiet[k] = done ? 0 : m_quiet[k] + 1;
                if (!rq[o]) leave = 1'b1;
                else if (done) begin
                    if (!lk[o]) leave = 1'b1;
                    else if (m_chain[k] >= LockMax - 1 && rq[3-o]) leave = 1'b1;
                    else if (m_chain[k] < LockMax - 1) m_chain[k]++;
                end else if (m_quiet[k] >= MaxHold) begin
                    leave = 1'b1;
                    m_tmo[k] = 1'b1;
                    m_ban[k][o] = 1'b1;
                end
                if (leave) begin
                    m_owner[k] = 0;
                    m_last[k]  = o;
                end
            end
            for (int i = 1; i < 3; i++) if (!rq[i]) m_ban[k][i] = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cmp_model(input int k, input string tag, input logic g1, input logic g2,
                             input logic sel, input logic busy, input logic tmo);
        chk({tag, " model m1_grant"}, 32'(g1), 32'(m_owner[k] == 1));
        chk({tag, " model m2_grant"}, 32'(g2), 32'(m_owner[k] == 2));
        chk({tag, " model bus_sel"}, 32'(sel), 32'(m_sel[k]));
        chk({tag, " model bus_busy"}, 32'(busy), 32'(m_owner[k] != 0));
        chk({tag, " model timeout"}, 32'(tmo), 32'(m_tmo[k]));
    endtask

    task automatic expect_all(input string tag, input logic g1, input logic g2, input logic sel,
                              input logic busy, input logic tmo);
        chk({tag, " rr m1_grant"}, 32'(if_rr.m1_grant), 32'(g1));
        chk({tag, " rr m2_grant"}, 32'(if_rr.m2_grant), 32'(g2));
        chk({tag, " rr bus_sel"}, 32'(if_rr.bus_sel), 32'(sel));
        chk({tag, " rr bus_busy"}, 32'(if_rr.bus_busy), 32'(busy));
        chk({tag, " rr timeout"}, 32'(if_rr.timeout_pulse), 32'(tmo));
        chk({tag, " fx m1_grant"}, 32'(if_fx.m1_grant), 32'(g1));
        chk({tag, " fx m2_grant"}, 32'(if_fx.m2_grant), 32'(g2));
        chk({tag, " fx bus_sel"}, 32'(if_fx.bus_sel), 32'(sel));
        chk({tag, " fx bus_busy"}, 32'(if_fx.bus_busy), 32'(busy));
        chk({tag, " fx timeout"}, 32'(if_fx.timeout_pulse), 32'(tmo));
    endtask

    // One clock: model advances on the edge, outputs are compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_model(0, "rr", if_rr.m1_grant, if_rr.m2_grant, if_rr.bus_sel, if_rr.bus_busy,
                  if_rr.timeout_pulse);
        cmp_model(1, "fx", if_fx.m1_grant, if_fx.m2_grant, if_fx.bus_sel, if_fx.bus_busy,
                  if_fx.timeout_pulse);
    endtask

    task automatic set_in(input logic a, input logic b, input logic c, input logic d,
                          input logic e);
        r1 = a; l1 = b; r2 = c; l2 = d; done = e;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        expect_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic r1, l1, r2, l2, done;
        logic g1, g2, sel, busy, tmo;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        model_reset();
        #1 reset = 1'b0;
        #2 expect_all("por", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Locked burst bounded to four transactions, then basic request/release.
        foreach (tbl[i]) begin
            set_in(tbl[i].r1, tbl[i].l1, tbl[i].r2, tbl[i].l2, tbl[i].done);
            tick();
            expect_all($sformatf("vec%0d", i), tbl[i].g1, tbl[i].g2, tbl[i].sel, tbl[i].busy,
                       tbl[i].tmo);
        end

        // Unbounded lock while master1 is quiet, then forced release once it asks.
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            done = 1'b1;
            tick();
            expect_all($sformatf("lock_free%0d", i), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        expect_all("lock_forced", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_all("lock_handover", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Tie-break: round-robin alternates, fixed priority keeps master1.
        reset_pulse();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_all("tie_first", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        expect_all("tie_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        done = 1'b0;
        tick();
        chk("tie_rr m2_grant", 32'(if_rr.m2_grant), 32'd1);
        chk("tie_rr bus_sel", 32'(if_rr.bus_sel), 32'd1);
        chk("tie_fx m1_grant", 32'(if_fx.m1_grant), 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        expect_all("tie_back", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Hold timeout with master2 waiting; master1 banned until it drops req.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 1; i < MaxHold; i++) begin
            if (i == 10) r2 = 1'b1;
            tick();
            expect_all("hold", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        tick();
        expect_all("timeout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_all("after_tmo", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        r2 = 1'b0;
        tick();
        tick();
        expect_all("banned", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        r1 = 1'b0;
        tick();
        r1 = 1'b1;
        tick();
        expect_all("unbanned", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        r1 = 1'b0;
        tick();

        // Asynchronous reset in the middle of a master2 grant.
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_all("pre_rst", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1 expect_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        r1 = 1'b1;
        tick();
        expect_all("post_rst_tie", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Random traffic against the model; the middle stretch rarely completes transactions.
        for (int c = 0; c < 3000; c++) begin
            int flip_div;
            int done_div;
            flip_div = (c >= 1000 && c < 2000) ? 200 : 8;
            done_div = (c >= 1000 && c < 2000) ? 100 : 4;
            if ($urandom_range(flip_div - 1) == 0) r1 = ~r1;
            if ($urandom_range(flip_div - 1) == 0) r2 = ~r2;
            l1 = $urandom_range(1);
            l2 = $urandom_range(1);
            done = ($urandom_range(done_div - 1) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
